// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request and data-memory bus between pipeline, load_store_unit and memory
// Ports: in_* request fields and combinational memory read data; o_* memory access, stall and load/trap results.
// modport slave is the LSU side; modport master is the pipeline/memory side.
interface load_store_unit_if;
  logic        in_Valid;
  logic        in_IsStore;
  logic [1:0]  in_Size;
  logic        in_Unsigned;
  logic [31:0] in_Address_dw;
  logic [31:0] in_WriteData_dw;
  logic [31:0] in_MemReadData_dw;
  logic [31:0] o_MemAddress_dw;
  logic [31:0] o_MemWriteData_dw;
  logic        o_MemWrite;
  logic        o_MemRead;
  logic        o_Busy;
  logic [31:0] o_LoadData_dw;
  logic        o_LoadValid;
  logic        o_Misaligned;
  modport slave (
    input  in_Valid, in_IsStore, in_Size, in_Unsigned, in_Address_dw, in_WriteData_dw, in_MemReadData_dw,
    output o_MemAddress_dw, o_MemWriteData_dw, o_MemWrite, o_MemRead, o_Busy, o_LoadData_dw, o_LoadValid, o_Misaligned
  );
  modport master (
    output in_Valid, in_IsStore, in_Size, in_Unsigned, in_Address_dw, in_WriteData_dw, in_MemReadData_dw,
    input  o_MemAddress_dw, o_MemWriteData_dw, o_MemWrite, o_MemRead, o_Busy, o_LoadData_dw, o_LoadValid, o_Misaligned
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-aligned data memory, sub-word stores via read-modify-write
// Ports: clk, reset (sync, active-high), bus (load_store_unit_if.slave).
// Macro LSU_MISALIGN_TRAP_EN: reject misaligned/reserved requests with o_Misaligned; otherwise force-align them.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic {IDLE, RMW_WRITE} state_t;
  state_t r_state;
  logic [DATA_WIDTH-1:0] r_addr, r_data, r_load_data;
  logic r_load_valid, r_misaligned;
  logic w_accept, w_mis, w_go, w_byte, w_half, w_word, w_rmw;
  logic [1:0] w_lane;
  logic [7:0] w_b;
  logic [15:0] w_h;
  logic [DATA_WIDTH-1:0] w_rd, w_wd, w_ext, w_mask, w_wsh, w_merged;
  always_comb begin
    w_rd     = bus.in_MemReadData_dw;
    w_wd     = bus.in_WriteData_dw;
    w_lane   = bus.in_Address_dw[1:0];
    w_accept = bus.in_Valid && r_state == IDLE && !reset;
    w_byte   = bus.in_Size == 2'b00;
    w_half   = bus.in_Size == 2'b01;
    w_word   = bus.in_Size[1];
`ifdef LSU_MISALIGN_TRAP_EN
    w_mis    = (w_half && w_lane[0]) || (bus.in_Size == 2'b10 && w_lane != 2'b00) || bus.in_Size == 2'b11;
`else
    w_mis    = 1'b0;
`endif
    w_go     = w_accept && !w_mis;
    w_rmw    = r_state == RMW_WRITE && !reset;
    w_b      = w_rd[{w_lane, 3'b000} +: 8];
    w_h      = w_lane[1] ? w_rd[31:16] : w_rd[15:0];
    w_ext    = w_byte ? {{24{!bus.in_Unsigned && w_b[7]}}, w_b}
             : w_half ? {{16{!bus.in_Unsigned && w_h[15]}}, w_h} : w_rd;
    // replicate store data across all lanes, then keep only the target lane(s)
    w_mask   = w_byte ? 32'h0000_00FF << {w_lane, 3'b000} : 32'h0000_FFFF << {w_lane[1], 4'b0000};
    w_wsh    = w_byte ? {4{w_wd[7:0]}} : {2{w_wd[15:0]}};
    w_merged = (w_rd & ~w_mask) | (w_wsh & w_mask);
    bus.o_MemAddress_dw   = w_rmw ? r_addr : {bus.in_Address_dw[31:2], 2'b00};
    bus.o_MemWriteData_dw = w_rmw ? r_data : w_wd;
    bus.o_MemWrite        = w_rmw || (r_state == IDLE && w_go && bus.in_IsStore && w_word);
    bus.o_MemRead         = w_go && !(bus.in_IsStore && w_word);
    bus.o_Busy            = w_rmw;
    bus.o_LoadData_dw     = r_load_data;
    bus.o_LoadValid       = r_load_valid;
    bus.o_Misaligned      = r_misaligned;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_load_valid <= w_go && !bus.in_IsStore;
      r_misaligned <= w_accept && w_mis;
      if (w_go && !bus.in_IsStore) r_load_data <= w_ext;
      if (r_state == RMW_WRITE) r_state <= IDLE;
      else if (w_go && bus.in_IsStore && !w_word) begin
        r_state <= RMW_WRITE;
        r_addr  <= {bus.in_Address_dw[31:2], 2'b00};
        r_data  <= w_merged;
      end
    end
  end
endmodule
